// File: rtl/cla_64bit.sv
// 64-bit carry-lookahead adder (carry-in 0) with a signed-overflow flag.
// Three lookahead levels:
//   - sixteen 4-bit blocks,
//   - four 16-bit sections,
//   - one top unit that produces the carries into bits 16/32/48 and the carry out.
// The combinational result is exported directly. A registered copy follows it
// with one cycle of latency.
module cla_64bit (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] A,
   input  logic [63:0] B,
   output logic [63:0] Sum,
   output logic        overflow,
   output logic        cout,
   output logic [63:0] Sum_r,
   output logic        overflow_r,
   output logic        cout_r
);

   localparam int DATA_W = 64;
   localparam int BLOCKS = DATA_W / 4;
   localparam int SECTS  = BLOCKS / 4;

   // Lookahead carries into positions 1..3 of a 4-wide group.
   // Inputs are the group's generate/propagate terms for positions 0..2 and the group carry-in.
   // Every carry is a flat sum of products, so nothing ripples.
   function automatic logic [3:1] la_carry(input logic [2:0] g,
                                           input logic [2:0] p,
                                           input logic       ci);
      logic [3:1] c;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      return c;
   endfunction

   // Group generate: the group produces a carry regardless of its carry-in.
   function automatic logic group_g(input logic [3:0] g, input logic [3:0] p);
      return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   endfunction

   // Group propagate: the group passes its carry-in straight through.
   function automatic logic group_p(input logic [3:0] p);
      return &p;
   endfunction

   logic [DATA_W-1:0] g;        // per-bit generate
   logic [DATA_W-1:0] p;        // per-bit propagate
   logic [DATA_W-1:0] c;        // carry into each bit
   logic [BLOCKS-1:0] blk_gg;   // 4-bit block generate
   logic [BLOCKS-1:0] blk_pg;   // 4-bit block propagate
   logic [BLOCKS-1:0] blk_ci;   // carry into each 4-bit block
   logic [SECTS-1:0]  sec_gg;   // 16-bit section generate
   logic [SECTS-1:0]  sec_pg;   // 16-bit section propagate
   logic [SECTS-1:0]  sec_ci;   // carry into each 16-bit section
   logic              c64;      // carry out of bit 63

   assign g = A & B;
   assign p = A ^ B;

   // Level 1: 4-bit blocks.
   // Each block computes its in-block carries from its block carry-in.
   // It also reduces its bits to one block generate/propagate pair.
   genvar k;
   generate
      for (k = 0; k < BLOCKS; k++) begin : g_blk
         assign c[4*k] = blk_ci[k];
         assign c[4*k+3:4*k+1] = la_carry(g[4*k+2:4*k], p[4*k+2:4*k], blk_ci[k]);
         assign blk_gg[k] = group_g(g[4*k+3:4*k], p[4*k+3:4*k]);
         assign blk_pg[k] = group_p(p[4*k+3:4*k]);
      end
   endgenerate

   // Level 2: 16-bit sections.
   // Each section turns four block pairs into the carry-ins of blocks 1..3.
   // Block 0 of a section takes the section carry-in directly.
   genvar s;
   generate
      for (s = 0; s < SECTS; s++) begin : g_sec
         logic [3:1] ci_int;
         assign ci_int = la_carry(blk_gg[4*s+2:4*s], blk_pg[4*s+2:4*s], sec_ci[s]);
         assign blk_ci[4*s]   = sec_ci[s];
         assign blk_ci[4*s+1] = ci_int[1];
         assign blk_ci[4*s+2] = ci_int[2];
         assign blk_ci[4*s+3] = ci_int[3];
         assign sec_gg[s] = group_g(blk_gg[4*s+3:4*s], blk_pg[4*s+3:4*s]);
         assign sec_pg[s] = group_p(blk_pg[4*s+3:4*s]);
      end
   endgenerate

   // Level 3: top unit.
   // The adder carry-in is 0, so section 0 starts from 0.
   // The carry out is simply the top-level group generate.
   logic [3:1] top_ci;
   assign top_ci    = la_carry(sec_gg[2:0], sec_pg[2:0], 1'b0);
   assign sec_ci[0] = 1'b0;
   assign sec_ci[1] = top_ci[1];
   assign sec_ci[2] = top_ci[2];
   assign sec_ci[3] = top_ci[3];
   assign c64       = group_g(sec_gg, sec_pg);

   assign Sum      = p ^ c;
   assign cout     = c64;
   // Signed overflow: the carry into the sign bit differs from the carry out of it.
   assign overflow = c[DATA_W-1] ^ c64;

   // Registered copy of the result.
   // It loads every cycle and clears immediately on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Sum_r      <= '0;
         overflow_r <= 1'b0;
         cout_r     <= 1'b0;
      end else begin
         Sum_r      <= Sum;
         overflow_r <= overflow;
         cout_r     <= cout;
      end
   end

endmodule

// File: tb/tb_cla_64bit.sv
// Directed bench for cla_64bit.
// Each vector carries hand-computed Sum/overflow/cout values.
// The combinational outputs are checked mid-cycle; the registered outputs are checked after the next edge.
module tb_cla_64bit;

   logic        clk;
   logic        reset;
   logic [63:0] A;
   logic [63:0] B;
   logic [63:0] Sum;
   logic        overflow;
   logic        cout;
   logic [63:0] Sum_r;
   logic        overflow_r;
   logic        cout_r;

   int total = 0;
   int bad   = 0;

   cla_64bit dut (
      .clk        (clk),
      .reset      (reset),
      .A          (A),
      .B          (B),
      .Sum        (Sum),
      .overflow   (overflow),
      .cout       (cout),
      .Sum_r      (Sum_r),
      .overflow_r (overflow_r),
      .cout_r     (cout_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Drive one operand pair after a falling edge and check the combinational outputs.
   // Then check the registered copy just after the following rising edge.
   task automatic vec(input string tag, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] es, input logic eov, input logic eco);
      @(negedge clk);
      A = a;
      B = b;
      #1;
      chk({tag, ".sum"}, Sum, es);
      chk({tag, ".ov"}, {63'd0, overflow}, {63'd0, eov});
      chk({tag, ".co"}, {63'd0, cout}, {63'd0, eco});
      @(posedge clk);
      #1;
      chk({tag, ".sum_r"}, Sum_r, es);
      chk({tag, ".ov_r"}, {63'd0, overflow_r}, {63'd0, eov});
      chk({tag, ".co_r"}, {63'd0, cout_r}, {63'd0, eco});
   endtask

   initial begin
      reset = 1'b1;
      A = 64'h0;
      B = 64'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.sum_r", Sum_r, 64'h0);
      chk("rst.ov_r", {63'd0, overflow_r}, 64'h0);
      chk("rst.co_r", {63'd0, cout_r}, 64'h0);
      @(negedge clk);
      reset = 1'b0;

      vec("inc",     64'h0000_0000_0000_0000, 64'h1,                   64'h0000_0000_0000_0001, 1'b0, 1'b0);
      vec("maxpos",  64'h7FFF_FFFF_FFFF_FFFF, 64'h1,                   64'h8000_0000_0000_0000, 1'b1, 1'b0);
      vec("allones", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                   64'h0000_0000_0000_0000, 1'b0, 1'b1);
      vec("minneg",  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1, 1'b1);
      vec("blk16",   64'h0000_0000_0000_FFFF, 64'h1,                   64'h0000_0000_0001_0000, 1'b0, 1'b0);
      vec("blk32",   64'h0000_0000_FFFF_FFFF, 64'h1,                   64'h0000_0001_0000_0000, 1'b0, 1'b0);
      vec("blk48",   64'h0000_FFFF_FFFF_FFFF, 64'h1,                   64'h0001_0000_0000_0000, 1'b0, 1'b0);
      vec("nib",     64'h0000_0000_0000_000F, 64'h1,                   64'h0000_0000_0000_0010, 1'b0, 1'b0);
      vec("m1m1",    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
      vec("alt",     64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
      vec("compl",   64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
      vec("negov",   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
      vec("posov",   64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
      vec("mid",     64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
      vec("mixed",   64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'h2222_2222_2222_2211, 1'b0, 1'b0);
      vec("pc3",     64'h0000_0000_0000_0FFE, 64'h3,                   64'h0000_0000_0000_1001, 1'b0, 1'b0);

      // Asynchronous reset asserted between edges with the register holding 0x1234.
      vec("hold",    64'h0000_0000_0000_1234, 64'h0,                   64'h0000_0000_0000_1234, 1'b0, 1'b0);
      @(negedge clk);
      A = 64'hFFFF_FFFF_FFFF_FFFF;
      B = 64'h1;
      #2;
      reset = 1'b1;
      #1;
      chk("arst.sum_r", Sum_r, 64'h0);
      chk("arst.ov_r", {63'd0, overflow_r}, 64'h0);
      chk("arst.co_r", {63'd0, cout_r}, 64'h0);
      chk("arst.sum", Sum, 64'h0);
      chk("arst.co", {63'd0, cout}, 64'h1);
      @(posedge clk);
      #1;
      chk("arst.held", Sum_r, 64'h0);
      @(negedge clk);
      reset = 1'b0;
      A = 64'h0000_0000_0000_0010;
      B = 64'h0000_0000_0000_0005;
      #1;
      chk("rel.sum", Sum, 64'h15);
      @(posedge clk);
      #1;
      chk("rel.sum_r", Sum_r, 64'h15);
      chk("rel.co_r", {63'd0, cout_r}, 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
